branch_resolve_ctrl: RTL and testbench

Sequential controller around the branch-condition evaluator. It owns the architectural NZCV flag register and tracks in-flight flag-setting instructions. It accepts one conditional branch at a time from decode and stalls it until the flags it depends on are final. It then resolves the branch and holds the redirect result for fetch until fetch acknowledges it.

---
 rtl/branch_pkg.sv | 34 +++
 rtl/cond_eval.sv | 42 ++++
 rtl/branch_resolve_ctrl.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller:
// condition-code encodings, FSM state type and NZCV bit positions.
package branch_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_RESOLVED   = 2'd2
  } br_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   cond     - condition code
//   n,z,c,v  - architectural flags
//   take     - 1 when the condition holds
module cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned COND_WIDTH = 4
) (
  input  logic [COND_WIDTH-1:0] cond,
  input  logic                  n,
  input  logic                  z,
  input  logic                  c,
  input  logic                  v,
  output logic                  take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_WIDTH'(COND_EQ): take = z;
      COND_WIDTH'(COND_NE): take = !z;
      COND_WIDTH'(COND_CS): take = c;
      COND_WIDTH'(COND_CC): take = !c;
      COND_WIDTH'(COND_MI): take = n;
      COND_WIDTH'(COND_PL): take = !n;
      COND_WIDTH'(COND_VS): take = v;
      COND_WIDTH'(COND_VC): take = !v;
      COND_WIDTH'(COND_HI): take = c && !z;
      COND_WIDTH'(COND_LS): take = !c || z;
      COND_WIDTH'(COND_GE): take = (n == v);
      COND_WIDTH'(COND_LT): take = (n != v);
      COND_WIDTH'(COND_GT): take = !z && (n == v);
      COND_WIDTH'(COND_LE): take = z || (n != v);
      COND_WIDTH'(COND_AL): take = 1'b1;
      COND_WIDTH'(COND_NV): take = 1'b0;
      default:              take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller. Owns the NZCV flag register, counts
// in-flight flag-setting instructions, accepts one conditional branch at a
// time, waits until its flags are final, resolves it and holds the redirect
// result until fetch acknowledges it.
// Ports:
//   flag_issue / flag_wr_en / flag_wr_nzcv - flag producer tracking + writeback
//   flush                                  - synchronous pipeline flush
//   br_*                                   - branch request from decode
//   res_*                                  - registered resolution result to fetch
//   issue_stall                            - pending tracker full
//   flags_q                                - architectural {N,Z,C,V}
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH             = 32,
  parameter int BRANCH_CONDITION_WIDTH = 4,
  parameter int PENDING_MAX            = 3,
  parameter int PENDING_WIDTH          = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flag_issue,
  input  logic                              flag_wr_en,
  input  logic [3:0]                        flag_wr_nzcv,
  input  logic                              flush,
  input  logic                              br_valid,
  output logic                              br_ready,
  input  logic [BRANCH_CONDITION_WIDTH-1:0] br_condition,
  input  logic [ADDR_WIDTH-1:0]             br_target,
  input  logic [ADDR_WIDTH-1:0]             br_fallthrough,
  input  logic                              br_pred_taken,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              res_taken,
  output logic [ADDR_WIDTH-1:0]             res_pc,
  output logic                              res_mispredict,
  output logic                              issue_stall,
  output logic [3:0]                        flags_q
);

  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = PENDING_WIDTH'(PENDING_MAX);

  br_state_e                         state_q, state_d;
  logic [PENDING_WIDTH-1:0]          pending_q, pending_d;
  logic [BRANCH_CONDITION_WIDTH-1:0] cond_q;
  logic [ADDR_WIDTH-1:0]             target_q, fall_q;
  logic                              pred_q;
  logic                              take;
  logic                              capture, evaluate;

  assign capture  = (state_q == ST_IDLE) && br_valid && !flush;
  // Only the registered count gates evaluation, so an issue in the same
  // cycle (a younger instruction) never delays this branch.
  assign evaluate = (state_q == ST_WAIT_FLAGS) && (pending_q == '0) && !flush;

  cond_eval #(.COND_WIDTH(BRANCH_CONDITION_WIDTH)) u_cond_eval (
    .cond (cond_q),
    .n    (flags_q[FLAG_N]),
    .z    (flags_q[FLAG_Z]),
    .c    (flags_q[FLAG_C]),
    .v    (flags_q[FLAG_V]),
    .take (take)
  );

  // Pending counter: saturates at both ends, flush clears it
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else if (flag_issue && !flag_wr_en) begin
      if (pending_q != PEND_MAX) pending_d = pending_q + 1'b1;
    end else if (!flag_issue && flag_wr_en) begin
      if (pending_q != '0) pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      flags_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (flag_wr_en) flags_q <= flag_wr_nzcv;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (br_valid)         state_d = ST_WAIT_FLAGS;
      ST_WAIT_FLAGS: if (pending_q == '0)  state_d = ST_RESOLVED;
      ST_RESOLVED:   if (res_ready)        state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // FSM outputs, all decoded from registers
  always_comb begin
    br_ready    = (state_q == ST_IDLE);
    res_valid   = (state_q == ST_RESOLVED);
    issue_stall = (pending_q == PEND_MAX);
  end

  // Branch capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q         <= '0;
      target_q       <= '0;
      fall_q         <= '0;
      pred_q         <= 1'b0;
      res_taken      <= 1'b0;
      res_pc         <= '0;
      res_mispredict <= 1'b0;
    end else begin
      if (capture) begin
        cond_q   <= br_condition;
        target_q <= br_target;
        fall_q   <= br_fallthrough;
        pred_q   <= br_pred_taken;
      end
      if (evaluate) begin
        res_taken      <= take;
        res_pc         <= take ? target_q : fall_q;
        res_mispredict <= (take != pred_q);
      end
    end
  end

  a_no_issue_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(flag_issue && !flag_wr_en && !flush && issue_stall)
  ) else $error("flag_issue asserted while issue_stall");

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_issue, flag_wr_en, flush, br_valid, br_pred_taken, res_ready;
  logic [3:0]  flag_wr_nzcv, br_condition;
  logic [31:0] br_target, br_fallthrough;
  logic        br_ready, res_valid, res_taken, res_mispredict, issue_stall;
  logic [31:0] res_pc;
  logic [3:0]  flags_q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (transaction-level view)
  int          m_pend;
  logic [3:0]  m_flags;
  bit          m_has_br;   // branch captured, not yet resolved
  bit          m_rv;       // result waiting for fetch
  logic [3:0]  m_cond;
  logic [31:0] m_tgt, m_fall, m_pc;
  logic        m_pred, m_taken, m_mis;

  branch_resolve_ctrl #(
    .ADDR_WIDTH(32), .BRANCH_CONDITION_WIDTH(4), .PENDING_MAX(3), .PENDING_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_issue(flag_issue), .flag_wr_en(flag_wr_en), .flag_wr_nzcv(flag_wr_nzcv),
    .flush(flush),
    .br_valid(br_valid), .br_ready(br_ready), .br_condition(br_condition),
    .br_target(br_target), .br_fallthrough(br_fallthrough), .br_pred_taken(br_pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_pc(res_pc), .res_mispredict(res_mispredict),
    .issue_stall(issue_stall), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Condition codes come in complementary pairs: odd code negates the even one.
  function automatic logic cond_ref(input int code, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_flags = '0; m_has_br = 0; m_rv = 0;
    m_cond = '0; m_tgt = '0; m_fall = '0; m_pred = 0;
    m_taken = 0; m_pc = '0; m_mis = 0;
  endtask

  task automatic model_step();
    int         old_pend;
    logic [3:0] old_flags;
    old_pend  = m_pend;
    old_flags = m_flags;
    if (flag_wr_en) m_flags = flag_wr_nzcv;
    if (flush) begin
      m_pend = 0; m_has_br = 0; m_rv = 0;
    end else begin
      m_pend = old_pend + int'(flag_issue) - int'(flag_wr_en);
      if (m_pend < 0) m_pend = 0;
      if (m_pend > 3) m_pend = 3;
      if (m_rv) begin
        if (res_ready) m_rv = 0;
      end else if (m_has_br) begin
        if (old_pend == 0) begin
          m_has_br = 0;
          m_rv     = 1;
          m_taken  = cond_ref(int'(m_cond), old_flags);
          m_pc     = m_taken ? m_tgt : m_fall;
          m_mis    = (m_taken != m_pred);
        end
      end else if (br_valid) begin
        m_has_br = 1;
        m_cond = br_condition; m_tgt = br_target; m_fall = br_fallthrough; m_pred = br_pred_taken;
      end
    end
  endtask

  task automatic check_all();
    check("br_ready", br_ready, !m_has_br && !m_rv);
    check("issue_stall", issue_stall, m_pend == 3);
    check("flags_q", flags_q, m_flags);
    check("res_valid", res_valid, m_rv);
    check("res_taken", res_taken, m_taken);
    check("res_pc", res_pc, m_pc);
    check("res_mispredict", res_mispredict, m_mis);
  endtask

  task automatic idle();
    flag_issue = 0; flag_wr_en = 0; flag_wr_nzcv = '0; flush = 0;
    br_valid = 0; br_condition = '0; br_target = '0; br_fallthrough = '0;
    br_pred_taken = 0; res_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int w;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Hazard-free path
    idle(); flag_wr_en = 1; flag_wr_nzcv = 4'b0100; tick();
    idle(); br_valid = 1; br_condition = 4'd0; br_target = 32'h100;
    br_fallthrough = 32'h4; br_pred_taken = 0; tick();
    check("hf_valid_n1", res_valid, 1'b0);
    idle(); tick();
    check("hf_valid_n2", res_valid, 1'b1);
    check("hf_taken", res_taken, 1'b1);
    check("hf_pc", res_pc, 32'h100);
    check("hf_mispredict", res_mispredict, 1'b1);

    // Backpressure, then a branch offered in the acknowledge cycle is refused
    idle();
    repeat (5) begin
      tick();
      check("bp_ready", br_ready, 1'b0);
      check("bp_pc", res_pc, 32'h100);
    end
    idle(); res_ready = 1; br_valid = 1; br_condition = 4'd14; tick();
    check("bp_release_valid", res_valid, 1'b0);
    check("bp_release_ready", br_ready, 1'b1);
    idle(); tick();
    check("bp_not_captured", br_ready, 1'b1);

    // Single hazard: LT must use the flags written by the retiring producer
    idle(); flag_issue = 1; tick();
    idle(); br_valid = 1; br_condition = 4'd11; br_target = 32'h200;
    br_fallthrough = 32'h8; br_pred_taken = 1; tick();
    idle();
    repeat (3) begin
      tick();
      check("hz_waiting", res_valid, 1'b0);
    end
    flag_wr_en = 1; flag_wr_nzcv = 4'b1000; tick();
    check("hz_write_cycle", res_valid, 1'b0);
    idle(); tick();
    check("hz_valid", res_valid, 1'b1);
    check("hz_taken", res_taken, 1'b1);
    check("hz_pc", res_pc, 32'h200);
    idle(); res_ready = 1; tick();

    // Counter boundaries
    idle(); flag_issue = 1;
    repeat (3) tick();
    check("cnt_full", issue_stall, 1'b1);
    flag_wr_en = 1; flag_wr_nzcv = 4'b0001; tick();
    check("cnt_issue_wr_full", issue_stall, 1'b1);
    idle(); flag_wr_en = 1;
    repeat (3) tick();
    check("cnt_drained", issue_stall, 1'b0);
    flag_wr_nzcv = 4'b0011; tick();
    check("cnt_wr_at_zero_flags", flags_q, 4'b0011);
    idle(); flag_issue = 1;
    repeat (2) tick();
    check("cnt_two", issue_stall, 1'b0);
    tick();
    check("cnt_three", issue_stall, 1'b1);
    idle(); flag_wr_en = 1; flag_wr_nzcv = 4'b0000;
    repeat (3) tick();

    // Flush in WAIT_FLAGS with two pending producers
    idle(); flag_issue = 1;
    repeat (2) tick();
    idle(); br_valid = 1; br_condition = 4'd14; br_target = 32'h300; tick();
    idle(); flush = 1; tick();
    check("fl_ready", br_ready, 1'b1);
    check("fl_stall", issue_stall, 1'b0);
    idle();
    repeat (3) begin
      tick();
      check("fl_no_valid", res_valid, 1'b0);
    end
    idle(); flush = 1; br_valid = 1; br_condition = 4'd14; tick();
    idle(); tick();
    check("fl_br_not_captured", br_ready, 1'b1);
    idle(); br_valid = 1; br_condition = 4'd14; br_target = 32'h400; tick();
    idle(); tick();
    check("fl_pending_cleared", res_valid, 1'b1);
    check("fl_pc", res_pc, 32'h400);
    idle(); res_ready = 1; tick();

    // Exhaustive condition table
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        idle(); flag_wr_en = 1; flag_wr_nzcv = 4'(f); tick();
        idle(); br_valid = 1; br_condition = 4'(c); br_target = $urandom;
        br_fallthrough = $urandom; br_pred_taken = 1'($urandom); tick();
        idle();
        w = 0;
        while (!res_valid && w < 8) begin
          tick();
          w++;
        end
        check("ex_timeout", w < 8, 1'b1);
        check("ex_taken", res_taken, cond_ref(c, 4'(f)));
        if (c == 14) check("ex_al", res_taken, 1'b1);
        if (c == 15) check("ex_nv", res_taken, 1'b0);
        idle(); res_ready = 1; tick();
      end
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      idle();
      flag_wr_en     = ($urandom_range(0, 9) < 3);
      flag_wr_nzcv   = 4'($urandom);
      flag_issue     = ($urandom_range(0, 9) < 3) && (m_pend < 3 || flag_wr_en);
      flush          = ($urandom_range(0, 29) == 0);
      br_valid       = ($urandom_range(0, 1) == 1);
      br_condition   = 4'($urandom);
      br_target      = $urandom;
      br_fallthrough = $urandom;
      br_pred_taken  = 1'($urandom);
      res_ready      = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
